// File: rtl/dnn_sched_pkg.sv
// Shared types, default layer geometry and width helpers for the DNN layer scheduler.
package dnn_sched_pkg;

  localparam int NUM_LAYERS_DEF = 3;
  localparam int MAX_N_DEF      = 784;

  // Element counts per layer boundary, network input first.
  localparam int LAYER_N [0:NUM_LAYERS_DEF] = '{784, 30, 30, 10};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_FEED = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } sched_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int sched_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of a counter that must hold the value n itself.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dnn_pingpong_buf.sv
// Two-bank ping-pong activation buffer: one write port, one registered read port.
// The bank-select bit names the source bank; the destination is the other one.
module dnn_pingpong_buf
  import dnn_sched_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int MAX_N  = 784,
  localparam int AW    = sched_w(MAX_N)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sel_clr,
  input  logic              i_swap,
  input  logic              i_wr_en,
  input  logic              i_wr_to_src,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem_a [0:MAX_N-1];
  logic [DATA_W-1:0] r_mem_b [0:MAX_N-1];
  logic              r_sel;
  logic              r_rd_data_valid_unused;
  logic [DATA_W-1:0] r_rd_data;
  logic              w_wr_bank;

  assign w_wr_bank = i_wr_to_src ? r_sel : ~r_sel;
  assign o_rd_data = r_rd_data;

  // Bank select: back to bank A when idle, flips at each layer boundary.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sel <= 1'b0;
    end else if (i_sel_clr) begin
      r_sel <= 1'b0;
    end else if (i_swap) begin
      r_sel <= ~r_sel;
    end
  end

  // Memory write port; contents are not reset so the banks map onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      if (w_wr_bank) begin
        r_mem_b[i_wr_addr] <= i_wr_data;
      end else begin
        r_mem_a[i_wr_addr] <= i_wr_data;
      end
    end
  end

  // Registered read from the source bank, one cycle of latency.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_data              <= '0;
      r_rd_data_valid_unused <= 1'b0;
    end else begin
      r_rd_data_valid_unused <= i_rd_en;
      if (i_rd_en) begin
        r_rd_data <= r_sel ? r_mem_b[i_rd_addr] : r_mem_a[i_rd_addr];
      end
    end
  end

endmodule

// File: rtl/dnn_layer_sched.sv
// Layer-serial DNN sequencer: loads one input vector from the stream, pushes it through
// every layer via the ping-pong buffer, tracks the final argmax and raises an interrupt.
module dnn_layer_sched
  import dnn_sched_pkg::*;
#(
  parameter int DATA_W                   = 16,
  parameter int NUM_LAYERS               = 3,
  parameter int MAX_N                    = 784,
  parameter int LAYER_N [0:NUM_LAYERS]   = dnn_sched_pkg::LAYER_N,
  localparam int LW                      = sched_w(NUM_LAYERS)
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic [31:0]       axis_in_data,
  input  logic              axis_in_data_valid,
  output logic              axis_in_data_ready,
  input  logic              soft_rst,
  input  logic              intr_clr,
  output logic [LW-1:0]     lyr_sel,
  output logic [DATA_W-1:0] lyr_in_data,
  output logic              lyr_in_valid,
  input  logic [DATA_W-1:0] lyr_out_data,
  input  logic              lyr_out_valid,
  output logic              busy,
  output logic [7:0]        res_class,
  output logic              intr,
  output logic              err
);

  localparam int CW = cnt_w(MAX_N);
  localparam int AW = sched_w(MAX_N);
  localparam logic [CW-1:0] N_FIRST = CW'(LAYER_N[0]);

  sched_state_e      r_state;
  logic [LW-1:0]     r_lyr;
  logic [CW-1:0]     r_in_cnt;
  logic [CW-1:0]     r_rd_cnt;
  logic [CW-1:0]     r_out_cnt;
  logic              r_ready;
  logic              r_lyr_in_valid;
  logic              r_busy;
  logic              r_intr;
  logic              r_err;
  logic [7:0]        r_res_class;
  logic [DATA_W-1:0] r_best_val;
  logic [7:0]        r_best_idx;

  logic [CW-1:0]     w_n_in;
  logic [CW-1:0]     w_n_out;
  logic              w_last;
  logic              w_out_full;
  logic              w_cap_acc;
  logic              w_cap_err;
  logic              w_load_hs;
  logic              w_rd_en;
  logic              w_swap;
  logic              w_sel_clr;
  logic              w_wr_en;
  logic              w_wr_to_src;
  logic [AW-1:0]     w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_unused;

  assign w_unused = &{1'b0, axis_in_data[31:DATA_W]};

  // Per-layer element counts and the handshake / capture decode for this cycle.
  always_comb begin
    w_n_in  = '0;
    w_n_out = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      w_n_in  = (r_lyr == LW'(k)) ? CW'(LAYER_N[k])     : w_n_in;
      w_n_out = (r_lyr == LW'(k)) ? CW'(LAYER_N[k + 1]) : w_n_out;
    end
    w_last      = (r_lyr == LW'(NUM_LAYERS - 1));
    w_out_full  = (r_out_cnt == w_n_out);
    // Results are captured in FEED or WAIT; anything else (or overflow) is an error.
    w_cap_acc   = lyr_out_valid && ((r_state == ST_FEED) || (r_state == ST_WAIT))
                  && (r_out_cnt < w_n_out);
    w_cap_err   = lyr_out_valid && !w_cap_acc;
    w_load_hs   = (r_state == ST_LOAD) && r_ready && axis_in_data_valid;
    w_rd_en     = (r_state == ST_FEED);
    w_swap      = (r_state == ST_WAIT) && w_out_full && !w_last;
    w_sel_clr   = (r_state == ST_IDLE) || soft_rst;
    w_wr_en     = w_load_hs || w_cap_acc;
    w_wr_to_src = (r_state == ST_LOAD);
    if (w_wr_to_src) begin
      w_wr_addr = AW'(r_in_cnt);
      w_wr_data = axis_in_data[DATA_W-1:0];
    end else begin
      w_wr_addr = AW'(r_out_cnt);
      w_wr_data = lyr_out_data;
    end
  end

  dnn_pingpong_buf #(
    .DATA_W (DATA_W),
    .MAX_N  (MAX_N)
  ) u_buf (
    .i_clk       (s_axi_aclk),
    .i_rst_n     (s_axi_aresetn),
    .i_sel_clr   (w_sel_clr),
    .i_swap      (w_swap),
    .i_wr_en     (w_wr_en),
    .i_wr_to_src (w_wr_to_src),
    .i_wr_addr   (w_wr_addr),
    .i_wr_data   (w_wr_data),
    .i_rd_en     (w_rd_en),
    .i_rd_addr   (AW'(r_rd_cnt)),
    .o_rd_data   (lyr_in_data)
  );

  // Main sequencer FSM with its counters and registered handshake/strobe outputs.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_state        <= ST_IDLE;
      r_lyr          <= '0;
      r_in_cnt       <= '0;
      r_rd_cnt       <= '0;
      r_out_cnt      <= '0;
      r_ready        <= 1'b0;
      r_lyr_in_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else if (soft_rst) begin
      r_state        <= ST_IDLE;
      r_lyr          <= '0;
      r_in_cnt       <= '0;
      r_rd_cnt       <= '0;
      r_out_cnt      <= '0;
      r_ready        <= 1'b0;
      r_lyr_in_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_lyr_in_valid <= w_rd_en;
      if (w_cap_acc) begin
        r_out_cnt <= r_out_cnt + CW'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (axis_in_data_valid) begin
            r_state   <= ST_LOAD;
            r_ready   <= 1'b1;
            r_busy    <= 1'b1;
            r_lyr     <= '0;
            r_in_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_out_cnt <= '0;
          end
        end
        ST_LOAD: begin
          if (w_load_hs) begin
            if (r_in_cnt == N_FIRST - CW'(1)) begin
              r_state  <= ST_FEED;
              r_ready  <= 1'b0;
              r_in_cnt <= '0;
            end else begin
              r_in_cnt <= r_in_cnt + CW'(1);
            end
          end
        end
        ST_FEED: begin
          if (r_rd_cnt == w_n_in - CW'(1)) begin
            r_state  <= ST_WAIT;
            r_rd_cnt <= '0;
          end else begin
            r_rd_cnt <= r_rd_cnt + CW'(1);
          end
        end
        ST_WAIT: begin
          if (w_out_full) begin
            if (w_last) begin
              r_state <= ST_DONE;
            end else begin
              r_state   <= ST_FEED;
              r_lyr     <= r_lyr + LW'(1);
              r_rd_cnt  <= '0;
              r_out_cnt <= '0;
            end
          end
        end
        ST_DONE: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_out_cnt <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error, on-the-fly argmax and the interrupt; these survive a soft reset.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_err       <= 1'b0;
      r_intr      <= 1'b0;
      r_res_class <= 8'd0;
      r_best_val  <= '0;
      r_best_idx  <= 8'd0;
    end else begin
      if (w_cap_err) begin
        r_err <= 1'b1;
      end
      // Strict greater-than keeps the lowest index on ties.
      if (w_cap_acc && w_last) begin
        if ((r_out_cnt == '0) || ($signed(lyr_out_data) > $signed(r_best_val))) begin
          r_best_val <= lyr_out_data;
          r_best_idx <= 8'(r_out_cnt);
        end
      end
      // A completing run sets intr even if a clear arrives in the same cycle.
      if (r_state == ST_DONE) begin
        r_intr      <= 1'b1;
        r_res_class <= r_best_idx;
      end else if (intr_clr) begin
        r_intr <= 1'b0;
      end
    end
  end

  assign axis_in_data_ready = r_ready;
  assign lyr_sel            = r_lyr;
  assign lyr_in_valid       = r_lyr_in_valid;
  assign busy               = r_busy;
  assign res_class          = r_res_class;
  assign intr               = r_intr;
  assign err                = r_err;

endmodule
